button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Upstream stage of the 2-bit mode/selection counter.
- Conditions a raw, bouncing push-button from the FPGA board: synchronises it, debounces it, and classifies presses.
- press_pulse drives the counter's count input, one cycle per press.
- long_pulse drives the counter's reset input, so a long hold returns the selection to 0.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles needed to accept a press or release (must be >= 2)
LONG_CYCLES, 50000000, cycles held in HELD before long_pulse (must be >= 2)
REPEAT_CYCLES, 10000000, auto-repeat period in LONG_HELD (used only with the optional feature)
ACTIVE_LOW, 1, 1 = btn_in reads 0 when pressed; 0 = btn_in reads 1 when pressed

Ports:
clk  input  1  system clock, rising-edge
rstn  input  1  reset: synchronous, active-high (asserted = 1)
btn_in  input  1  raw asynchronous button pin
btn_level  output  1  debounced pressed level (1 = pressed)
press_pulse  output  1  one-cycle strobe per accepted press
release_pulse  output  1  one-cycle strobe per accepted release
long_pulse  output  1  one-cycle strobe when a hold reaches LONG_CYCLES

Behaviour:
- Input conditioning:
  - Two-flop synchroniser (s1, s2); polarity normalised so act = 1 means pressed.
  - On reset, s1 and s2 load the inactive level.
- Reset (rstn = 1 at a clock edge):
  - State = IDLE; all counters = 0; all outputs = 0.
  - Reset has priority over all other logic.
  - Reset mid-press abandons the press. A button still held after reset is re-debounced and produces a fresh press_pulse.
- Counters:
  - Debounce counter deb_cnt: width $clog2(DEBOUNCE_CYCLES).
  - Hold counter hold_cnt: width $clog2(LONG_CYCLES).
  - Repeat counter rep_cnt: width $clog2(REPEAT_CYCLES).
  - Counters saturate and never wrap.
- States:
  - IDLE:
    - act = 1 -> PRESS_WAIT, deb_cnt = 0.
  - PRESS_WAIT:
    - act = 0 -> IDLE (bounce rejected, no output).
    - act = 1 and deb_cnt = DEBOUNCE_CYCLES-1 -> HELD, press_pulse = 1, hold_cnt = 0.
    - Otherwise deb_cnt++.
  - HELD:
    - act = 0 -> RELEASE_WAIT, deb_cnt = 0.
    - Else if hold_cnt = LONG_CYCLES-1 -> LONG_HELD, long_pulse = 1.
    - Else hold_cnt++.
  - LONG_HELD:
    - act = 0 -> RELEASE_WAIT, deb_cnt = 0. A long_flag records that release began from LONG_HELD.
  - RELEASE_WAIT:
    - act = 1 -> back to HELD (or LONG_HELD if long_flag) with no new press_pulse. hold_cnt is preserved, not cleared.
    - act = 0 and deb_cnt = DEBOUNCE_CYCLES-1 -> IDLE, release_pulse = 1, long_flag = 0.
    - Otherwise deb_cnt++.
- Outputs:
  - All outputs are registered.
  - Each strobe is high for exactly one cycle.
  - At most one strobe per cycle, except press_pulse and long_pulse may coincide only under AUTO_REPEAT_EN.
  - btn_level = 1 in HELD, LONG_HELD and RELEASE_WAIT; 0 in IDLE and PRESS_WAIT. Registered alongside the state.
- Latency:
  - Counting the first edge at which s1 samples a stably active pin as edge 1, press_pulse is high after edge DEBOUNCE_CYCLES+3.
  - Release latency is the same.
  - long_pulse is high LONG_CYCLES cycles after press_pulse.
- Boundary rules:
  - A bounce shorter than DEBOUNCE_CYCLES in either direction produces no strobe.
  - One press yields exactly one press_pulse and one release_pulse, and at most one long_pulse (without the optional feature).

Optional Feature:
Macro BUTTON_AUTO_REPEAT_EN.
- Defined:
  - rep_cnt clears on entry to LONG_HELD.
  - In LONG_HELD, press_pulse fires when rep_cnt = REPEAT_CYCLES-1, then rep_cnt returns to 0.
  - The counter steps repeatedly while the button is held.
  - rep_cnt pauses during RELEASE_WAIT bounces.
- Undefined:
  - No repeat logic is synthesised; REPEAT_CYCLES is ignored.
  - LONG_HELD only waits for release.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, ACTIVE_LOW=1):
- Clean press: btn_in 1->0 held 30 cycles, then 1 -> one press_pulse at edge 7, btn_level 1 from edge 7, long_pulse 20 cycles later. One release_pulse 7 edges after btn_in returns to 1.
- Bounce rejection: btn_in low 3 cycles, high 2, low 2, then high -> no strobes, btn_level stays 0.
- Release bounce: held press, btn_in high 2 cycles then low again for 5, then high -> no release_pulse during the bounce, no second press_pulse, exactly one final release_pulse.
- Reset mid-press: assert rstn for 1 cycle while in HELD with btn_in still low -> all outputs 0 at the next edge; a new press_pulse 7 edges after rstn deasserts.
- Auto-repeat (macro defined): hold 50 cycles -> press_pulse at edge 7, long_pulse at edge 27, repeat press_pulses every 8 cycles thereafter. Macro undefined: only the edge-7 press_pulse.
- Polarity: ACTIVE_LOW=0, btn_in 0->1 held 10 cycles -> press_pulse at edge 7.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner: synchronises, debounces and classifies a raw push-button pin.
// Build option: define BUTTON_AUTO_REPEAT_EN to emit repeated press_pulse strobes during a long hold.
// Ports:
//   clk           rising-edge system clock
//   rstn          synchronous reset, active-high (1 = reset)
//   btn_in        raw asynchronous button pin
//   btn_level     debounced pressed level (1 = pressed)
//   press_pulse   one-cycle strobe per accepted press (plus auto-repeats when enabled)
//   release_pulse one-cycle strobe per accepted release
//   long_pulse    one-cycle strobe when a hold reaches LONG_CYCLES
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned LONG_CYCLES     = 50000000,
  parameter int unsigned REPEAT_CYCLES   = 10000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int HW = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 1);
  // Pin level when the button is not pressed.
  localparam logic INACTIVE = ACTIVE_LOW ? 1'b1 : 1'b0;

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    LONG_HELD,
    RELEASE_WAIT
  } state_t;

  state_t          state_q, state_d;
  logic            s1_q, s2_q;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d;
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
  logic            long_flag_q, long_flag_d;
  logic            btn_level_q, btn_level_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            act;
`ifdef BUTTON_AUTO_REPEAT_EN
  logic [RW-1:0]   rep_cnt_q, rep_cnt_d;
`endif

  // Normalised pressed level from the synchronised pin.
  assign act = s2_q ^ INACTIVE;

  always_comb begin
    state_d     = state_q;
    deb_cnt_d   = deb_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    long_flag_d = long_flag_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    long_d      = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (act) begin
          state_d   = PRESS_WAIT;
          deb_cnt_d = '0;
        end
      end
      PRESS_WAIT: begin
        if (!act) begin
          state_d = IDLE;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d    = HELD;
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      HELD: begin
        if (!act) begin
          state_d   = RELEASE_WAIT;
          deb_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = LONG_HELD;
          long_d  = 1'b1;
`ifdef BUTTON_AUTO_REPEAT_EN
          rep_cnt_d = '0;
`endif
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      LONG_HELD: begin
        if (!act) begin
          state_d     = RELEASE_WAIT;
          deb_cnt_d   = '0;
          long_flag_d = 1'b1;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (rep_cnt_q == REP_LAST) begin
          press_d   = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RW'(1);
        end
`endif
      end
      RELEASE_WAIT: begin
        // A bounce back to active resumes the hold; hold_cnt (and rep_cnt)
        // keep their values so a bouncy release cannot restart the timers.
        if (act) begin
          state_d = long_flag_q ? LONG_HELD : HELD;
        end else if (deb_cnt_q == DEB_LAST) begin
          state_d     = IDLE;
          release_d   = 1'b1;
          long_flag_d = 1'b0;
        end else begin
          deb_cnt_d = deb_cnt_q + DW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    btn_level_d = (state_d == HELD) || (state_d == LONG_HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      s1_q        <= INACTIVE;
      s2_q        <= INACTIVE;
      state_q     <= IDLE;
      deb_cnt_q   <= '0;
      hold_cnt_q  <= '0;
      long_flag_q <= 1'b0;
      btn_level_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      long_q      <= 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q   <= '0;
`endif
    end else begin
      s1_q        <= btn_in;
      s2_q        <= s1_q;
      state_q     <= state_d;
      deb_cnt_q   <= deb_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      long_flag_q <= long_flag_d;
      btn_level_q <= btn_level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
`ifdef BUTTON_AUTO_REPEAT_EN
      rep_cnt_q   <= rep_cnt_d;
`endif
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.
// Instance u_lo uses ACTIVE_LOW=1, instance u_hi uses ACTIVE_LOW=0; both share clock and reset.
// Edge e counts posedges after a pin change; outputs are sampled 1 time unit after each edge.
module tb_button_conditioner;

  logic clk = 1'b0;
  logic rstn;
  logic btn_lo, btn_hi;
  logic lvl_lo, prs_lo, rel_lo, lng_lo;
  logic lvl_hi, prs_hi, rel_hi, lng_hi;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b1)
  ) u_lo (
    .clk(clk), .rstn(rstn), .btn_in(btn_lo),
    .btn_level(lvl_lo), .press_pulse(prs_lo), .release_pulse(rel_lo), .long_pulse(lng_lo)
  );

  button_conditioner #(
    .DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8), .ACTIVE_LOW(1'b0)
  ) u_hi (
    .clk(clk), .rstn(rstn), .btn_in(btn_hi),
    .btn_level(lvl_hi), .press_pulse(prs_hi), .release_pulse(rel_hi), .long_pulse(lng_hi)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int e, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, e, obs, exp);
    end
  endtask

  task automatic chk_lo(input string tag, input int e,
                        input logic lvl, input logic prs, input logic rel, input logic lng);
    chk({tag, ".level"},   e, lvl_lo, lvl);
    chk({tag, ".press"},   e, prs_lo, prs);
    chk({tag, ".release"}, e, rel_lo, rel);
    chk({tag, ".long"},    e, lng_lo, lng);
  endtask

  task automatic chk_hi(input string tag, input int e,
                        input logic lvl, input logic prs, input logic rel, input logic lng);
    chk({tag, ".level"},   e, lvl_hi, lvl);
    chk({tag, ".press"},   e, prs_hi, prs);
    chk({tag, ".release"}, e, rel_hi, rel);
    chk({tag, ".long"},    e, lng_hi, lng);
  endtask

  // Release the active-low button and expect release_pulse at edge 7.
  task automatic release_lo(input string tag);
    btn_lo = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk_lo(tag, e, e < 7, 1'b0, e == 7, 1'b0);
    end
  endtask

  initial begin
    bit rep_en;
`ifdef BUTTON_AUTO_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif
    rstn   = 1'b1;
    btn_lo = 1'b1;
    btn_hi = 1'b0;
    repeat (3) tick();
    chk_lo("reset_lo", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_hi("reset_hi", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    repeat (5) tick();
    chk_lo("idle_lo", 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clean press held 30 cycles: press at 7, long at 27.
    btn_lo = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      chk_lo("clean", e, e >= 7, e == 7, 1'b0, e == 27);
    end
    release_lo("clean_rel");
    repeat (5) tick();

    // Bounce rejection: low 3, high 2, low 2, then high.
    btn_lo = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      tick();
      chk_lo("bounce", e, 1'b0, 1'b0, 1'b0, 1'b0);
      if (e == 3) btn_lo = 1'b1;
      if (e == 5) btn_lo = 1'b0;
      if (e == 7) btn_lo = 1'b1;
    end

    // Release bounce: press, high 2, low 5, then final release.
    btn_lo = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      chk_lo("rb_press", e, e >= 7, e == 7, 1'b0, 1'b0);
    end
    btn_lo = 1'b1;
    for (int e = 1; e <= 2; e++) begin
      tick();
      chk_lo("rb_high", e, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    btn_lo = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk_lo("rb_low", e, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    release_lo("rb_final");
    repeat (5) tick();

    // Reset mid-press while HELD with the pin still active.
    btn_lo = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk_lo("mid_press", e, e >= 7, e == 7, 1'b0, 1'b0);
    end
    rstn = 1'b1;
    tick();
    chk_lo("mid_reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    rstn = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk_lo("after_reset", e, e >= 7, e == 7, 1'b0, 1'b0);
    end
    release_lo("after_reset_rel");
    repeat (5) tick();

    // Long hold of 50 cycles, release driven after edge 50.
    btn_lo = 1'b0;
    for (int e = 1; e <= 62; e++) begin
      logic exp_prs;
      tick();
      exp_prs = (e == 7) ||
                (rep_en && e >= 35 && e <= 52 && ((e - 35) % 8) == 0);
      chk_lo("long_hold", e, e >= 7 && e < 57, exp_prs, e == 57, e == 27);
      if (e == 50) btn_lo = 1'b1;
    end
    repeat (5) tick();

    // Polarity: active-high instance, pin high for 10 cycles.
    btn_hi = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk_hi("pol_press", e, e >= 7, e == 7, 1'b0, 1'b0);
    end
    btn_hi = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      tick();
      chk_hi("pol_rel", e, e < 7, 1'b0, e == 7, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
